sqrl_uart_rx_ctrl: RTL

//  8N1 UART receive sequencer. Consumes the synchronised, majority-filtered rx line
//  (no further sync inside). Detects start bits, times bit centres with a baud counter
//  and assembles LSB-first bytes. Presents each byte on a valid/ready interface with

---
 rtl/sqrl_uart_rx_ctrl_pkg.sv | 21 ++
 rtl/sqrl_uart_rx_ctrl_baud_tick.sv | 41 ++++
 rtl/sqrl_uart_rx_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sqrl_uart_rx_ctrl_pkg.sv
// ============================================================================
// Module  : sqrl_uart_rx_ctrl_pkg
// Brief   : Shared UART state encodings and frame geometry (rx and tx).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sqrl_uart_rx_ctrl_pkg;

  localparam int unsigned c_uart_data_bits = 8;
  localparam int unsigned c_bit_idx_w      = $clog2(c_uart_data_bits);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_start = 3'd1;
  localparam logic [2:0] c_st_data  = 3'd2;
  localparam logic [2:0] c_st_stop  = 3'd3;
  localparam logic [2:0] c_st_break = 3'd4;

endpackage

`default_nettype wire

// File: rtl/sqrl_uart_rx_ctrl_baud_tick.sv
// ============================================================================
// Module  : sqrl_uart_baud_tick
// Brief   : Baud counter producing half-bit and full-bit centre strobes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sqrl_uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic half_tick,
  output logic full_tick
);

  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] c_full_last = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // clear wins over en so the owner can restart timing on the strobe cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign half_tick = en && (r_cnt == c_half_last);
  assign full_tick = en && (r_cnt == c_full_last);

endmodule

`default_nettype wire

// File: rtl/sqrl_uart_rx_ctrl.sv
// ============================================================================
// Module  : sqrl_uart_rx_ctrl
// Brief   : 8N1 UART receive sequencer with valid/ready byte output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sqrl_uart_rx_ctrl
  import sqrl_uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [c_bit_idx_w-1:0] c_last_bit = c_bit_idx_w'(c_uart_data_bits - 1);

  logic [2:0]                  r_state;
  logic [c_bit_idx_w-1:0]      r_bit_idx;
  logic [c_uart_data_bits-1:0] r_shift;
  logic [7:0]                  r_rx_data;
  logic                        r_rx_valid;
  logic                        r_frame_err;
  logic                        r_overrun;

  logic w_half_tick;
  logic w_full_tick;
  logic w_cnt_en;
  logic w_cnt_clear;
  logic w_deliver;
  logic w_accept;

  assign w_cnt_en = (r_state == c_st_start) || (r_state == c_st_data) ||
                    (r_state == c_st_stop);

  // Counter restarts from zero after every sampling point it produced
  assign w_cnt_clear = (r_state == c_st_idle) || (r_state == c_st_break) ||
                       ((r_state == c_st_start) && w_half_tick) ||
                       (((r_state == c_st_data) || (r_state == c_st_stop)) && w_full_tick);

  assign w_deliver = (r_state == c_st_stop) && w_full_tick && rx;
  assign w_accept  = r_rx_valid && rx_ready;

  sqrl_uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud_tick (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_cnt_clear),
    .en        (w_cnt_en),
    .half_tick (w_half_tick),
    .full_tick (w_full_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_st_idle;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (!rx) r_state <= c_st_start;
        end
        c_st_start: begin
          if (w_half_tick) begin
            r_state   <= rx ? c_st_idle : c_st_data;
            r_bit_idx <= '0;
          end
        end
        c_st_data: begin
          if (w_full_tick) begin
            r_shift[r_bit_idx] <= rx;
            if (r_bit_idx == c_last_bit) begin
              r_state <= c_st_stop;
            end else begin
              r_bit_idx <= r_bit_idx + c_bit_idx_w'(1);
            end
          end
        end
        c_st_stop: begin
          if (w_full_tick) r_state <= rx ? c_st_idle : c_st_break;
        end
        c_st_break: begin
          if (rx) r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // Output holding register: a new byte replaces the old only if the old one
  // is gone or is being consumed in this very cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= (r_state == c_st_stop) && w_full_tick && !rx;
      r_overrun   <= 1'b0;
      if (w_deliver) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != c_st_idle);

endmodule

`default_nettype wire
